// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: raw X/Y counters, DAC sync/blank, line/frame strobes.
// Optional macro VGA_PIPE_ALIGN_EN delays HS/VS/BLANK_N/active by one cycle to match registered RGB.
module vga_sync_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  output logic [9:0] VGA_X,
  output logic [9:0] VGA_Y,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       run_q, run_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;

  always_comb begin
    run_d   = 1'b1;
    x_d     = '0;
    y_d     = '0;
    // The first edge after reset re-presents (0,0) with valid decodes; counting starts on the next one.
    if (run_q) begin
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
        y_d = y_q;
      end
    end
    hs_d    = !(x_d < H_SYNC_C);
    vs_d    = !(y_d < V_SYNC_C);
    blank_d = (x_d >= H_VIS_LO) && (x_d <= H_VIS_HI) &&
              (y_d >= V_VIS_LO) && (y_d <= V_VIS_HI);
    ls_d    = run_q && (x_d == '0);
    fs_d    = ls_d && (y_d == '0);
    fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      run_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  logic hs_dly_q, hs_dly_d;
  logic vs_dly_q, vs_dly_d;
  logic blank_dly_q, blank_dly_d;

  always_comb begin
    hs_dly_d    = hs_q;
    vs_dly_d    = vs_q;
    blank_dly_d = blank_q;
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      hs_dly_q    <= 1'b0;
      vs_dly_q    <= 1'b0;
      blank_dly_q <= 1'b0;
    end else begin
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      blank_dly_q <= blank_dly_d;
    end
  end

  assign VGA_HS      = hs_dly_q;
  assign VGA_VS      = vs_dly_q;
  assign VGA_BLANK_N = blank_dly_q;
  assign active      = blank_dly_q;
`else
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign active      = blank_q;
`endif

  assign VGA_X       = x_q;
  assign VGA_Y       = y_q;
  assign VGA_SYNC_N  = 1'b0;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: a default-timing instance plus a tiny-timing instance (fast frame wrap),
// both compared every cycle against a position-from-elapsed-cycles reference model.
module tb_vga_sync_gen;

`ifdef VGA_PIPE_ALIGN_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic VGA_CLK = 1'b0;
  logic reset   = 1'b1;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_bn, d_sn, d_act, d_ls, d_fs;
  logic       s_hs, s_vs, s_bn, s_sn, s_act, s_ls, s_fs;
  logic [7:0] d_fc, s_fc;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned e = 0;   // clock edges seen since the last reset release

  always #5 VGA_CLK = ~VGA_CLK;

  vga_sync_gen u_dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .VGA_X(d_x), .VGA_Y(d_y),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn),
    .active(d_act), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_sync_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(3), .V_FP(1)
  ) u_sml (
    .VGA_CLK(VGA_CLK), .reset(reset), .VGA_X(s_x), .VGA_Y(s_y),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn),
    .active(s_act), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected output vector from elapsed edges: position p advances once per edge after the first.
  function automatic logic [34:0] model(input int unsigned edges,
      input int unsigned hs, input int unsigned hbp, input int unsigned ha, input int unsigned hfp,
      input int unsigned vs, input int unsigned vbp, input int unsigned va, input int unsigned vfp);
    int unsigned ht, vt, p, q, x, y, qx, qy;
    logic hsync, vsync, vis, ls, fs;
    logic [7:0] fc;
    ht = hs + hbp + ha + hfp;
    vt = vs + vbp + va + vfp;
    p  = (edges == 0) ? 0 : edges - 1;
    x  = p % ht;
    y  = (p / ht) % vt;
    ls = (p > 0) && (x == 0);
    fs = ls && (y == 0);
    fc = 8'((p / (ht * vt)) % 256);
    q  = (PIPE && p > 0) ? p - 1 : p;
    qx = q % ht;
    qy = (q / ht) % vt;
    hsync = (qx >= hs);
    vsync = (qy >= vs);
    vis   = (qx >= hs + hbp) && (qx < hs + hbp + ha) && (qy >= vs + vbp) && (qy < vs + vbp + va);
    return {10'(x), 10'(y), hsync, vsync, vis, 1'b0, vis, ls, fs, fc};
  endfunction

  function automatic logic [34:0] obs_def();
    return {d_x, d_y, d_hs, d_vs, d_bn, d_sn, d_act, d_ls, d_fs, d_fc};
  endfunction

  function automatic logic [34:0] obs_sml();
    return {s_x, s_y, s_hs, s_vs, s_bn, s_sn, s_act, s_ls, s_fs, s_fc};
  endfunction

  task automatic compare_all();
    check("def", obs_def(), model(e, 96, 48, 640, 16, 2, 33, 480, 10));
    check("sml", obs_sml(), model(e, 2, 2, 4, 2, 2, 2, 3, 1));
  endtask

  task automatic step();
    @(posedge VGA_CLK);
    #1;
    if (!reset) e++;
    compare_all();
  endtask

  int unsigned p, hs_low, ls_cnt, sfs_cnt;
  bit wrap_seen;

  initial begin
    hs_low = 0; ls_cnt = 0; sfs_cnt = 0; wrap_seen = 0;
    repeat (3) step();
    check("reset_def_zero", obs_def(), '0);
    check("reset_sml_zero", obs_sml(), '0);
    @(negedge VGA_CLK);
    reset = 1'b0;

    // First line, visible-window corners at row 35, and many small-instance frames.
    for (int i = 0; i < 28900; i++) begin
      step();
      p = e - 1;
      if (p < 800 && !d_hs) hs_low++;
      if (p >= 1 && p <= 800 && d_ls) ls_cnt++;
      if (p == 799) check("hs_low_cycles", 35'(hs_low), PIPE ? 35'd97 : 35'd96);
      if (p == 800) begin
        check("first_wrap", {14'd0, d_x, d_y, d_ls}, {14'd0, 10'd0, 10'd1, 1'b1});
        check("line_start_once", 35'(ls_cnt), 35'd1);
      end
      if (p == 95)  check("hs_x95",  35'(d_hs), 35'd0);
      if (p == 96)  check("hs_x96",  35'(d_hs), PIPE ? 35'd0 : 35'd1);
      if (p == 97)  check("hs_x97",  35'(d_hs), 35'd1);
      if (p == 35*800 + 143) check("blank_143_35", 35'(d_bn), 35'd0);
      if (p == 35*800 + 144) check("blank_144_35", 35'(d_bn), PIPE ? 35'd0 : 35'd1);
      if (p == 35*800 + 145) check("blank_145_35", 35'(d_bn), 35'd1);
      if (p == 35*800 + 784) check("blank_784_35", 35'(d_bn), PIPE ? 35'd1 : 35'd0);
      if (p == 35*800 + 785) check("blank_785_35", 35'(d_bn), 35'd0);
      if (s_fs) sfs_cnt++;
      if (sfs_cnt == 256 && !wrap_seen) begin
        wrap_seen = 1;
        check("sml_fc_wrap", {26'd0, s_fs, s_fc}, {26'd0, 1'b1, 8'd0});
      end
    end
    check("sml_wrap_reached", 35'(wrap_seen), 35'd1);

    // Random mid-frame resets of random length.
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(30, 3000)) step();
      #2;
      reset = 1'b1;
      e = 0;
      #1;
      check("async_reset_def", obs_def(), '0);
      check("async_reset_sml", obs_sml(), '0);
      repeat ($urandom_range(1, 4)) step();
      @(negedge VGA_CLK);
      reset = 1'b0;
      step();
      check("restart_no_fs", {25'd0, d_x, d_fs, s_fs}, '0);
      step();
      check("restart_x1", {25'd0, d_x}, {25'd0, 10'd1});
    end
    repeat (200) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
